axis_insert_arbiter: RTL

AXIS_INSERT_ARBITER -- requirements
Module: axis_insert_arbiter

---
 rtl/axis_insert_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axis_insert_arbiter.sv
// axis_insert_arbiter
//   Round-robin arbiter that gives one of NUM_CH channels exclusive use of a
//   shared header inserter. Each grant carries exactly one header beat and one
//   payload packet. After both have been handed over, the arbiter returns to
//   IDLE for one cycle and then re-arbitrates.
//
// Ports
//   clk, rst             single clock; synchronous active-high reset
//   ch_en[NUM_CH]        per-channel arbitration enable
//   s_hdr_*              per-channel header streams (flattened, ch i at [i*W +: W])
//   s_dat_*              per-channel payload streams (flattened)
//   m_hdr_*              header stream of the granted channel, to the inserter
//   m_dat_*              payload stream of the granted channel (combinational pass-through)
//   grant[NUM_CH]        registered one-hot owner; all zeros when idle
//   busy                 registered; high while a channel owns the inserter
module axis_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_CH       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_en,

    input  logic [NUM_CH-1:0]              s_hdr_tvalid,
    input  logic [NUM_CH*DATA_WD-1:0]      s_hdr_tdata,
    input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_hdr_tkeep,
    output logic [NUM_CH-1:0]              s_hdr_tready,

    input  logic [NUM_CH-1:0]              s_dat_tvalid,
    input  logic [NUM_CH*DATA_WD-1:0]      s_dat_tdata,
    input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_dat_tkeep,
    input  logic [NUM_CH-1:0]              s_dat_tlast,
    output logic [NUM_CH-1:0]              s_dat_tready,

    output logic                           m_hdr_tvalid,
    output logic [DATA_WD-1:0]             m_hdr_tdata,
    output logic [DATA_BYTE_WD-1:0]        m_hdr_tkeep,
    input  logic                           m_hdr_tready,

    output logic                           m_dat_tvalid,
    output logic [DATA_WD-1:0]             m_dat_tdata,
    output logic [DATA_BYTE_WD-1:0]        m_dat_tkeep,
    output logic                           m_dat_tlast,
    input  logic                           m_dat_tready,

    output logic [NUM_CH-1:0]              grant,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_CH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state;
    logic [PW-1:0]   gidx;      // binary index of the owner, drives the muxes
    logic [PW-1:0]   ptr;       // last granted channel; search starts at ptr+1
    logic            hdr_done;
    logic            pkt_done;

    logic [NUM_CH-1:0] req;
    logic              arb_found;
    logic [PW-1:0]     arb_idx;
    logic              hdr_hs;
    logic              pkt_hs;
    int                j;

    assign req = s_hdr_tvalid & ch_en;

    // Round-robin search: first requester at ptr+1, ptr+2, ... wrapping, so
    // the channel granted last time is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        j         = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!arb_found && req[j]) begin
                arb_found = 1'b1;
                arb_idx   = PW'(j);
            end
        end
    end

    // Output muxing. Everything is forced to zero outside ACTIVE; once a
    // stream's done flag is set that stream is closed for the rest of the grant.
    always_comb begin
        m_hdr_tvalid = 1'b0;
        m_hdr_tdata  = '0;
        m_hdr_tkeep  = '0;
        m_dat_tvalid = 1'b0;
        m_dat_tdata  = '0;
        m_dat_tkeep  = '0;
        m_dat_tlast  = 1'b0;
        s_hdr_tready = '0;
        s_dat_tready = '0;
        if (state == ACTIVE) begin
            m_hdr_tvalid       = s_hdr_tvalid[gidx] & ~hdr_done;
            m_hdr_tdata        = s_hdr_tdata[int'(gidx)*DATA_WD +: DATA_WD];
            m_hdr_tkeep        = s_hdr_tkeep[int'(gidx)*DATA_BYTE_WD +: DATA_BYTE_WD];
            s_hdr_tready[gidx] = m_hdr_tready & ~hdr_done;
            m_dat_tvalid       = s_dat_tvalid[gidx] & ~pkt_done;
            m_dat_tdata        = s_dat_tdata[int'(gidx)*DATA_WD +: DATA_WD];
            m_dat_tkeep        = s_dat_tkeep[int'(gidx)*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_dat_tlast        = s_dat_tlast[gidx];
            s_dat_tready[gidx] = m_dat_tready & ~pkt_done;
        end
    end

    assign hdr_hs = m_hdr_tvalid & m_hdr_tready;
    assign pkt_hs = m_dat_tvalid & m_dat_tready & m_dat_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            gidx     <= '0;
            ptr      <= PW'(NUM_CH - 1);
            hdr_done <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                        grant <= NUM_CH'(1) << arb_idx;
                        gidx  <= arb_idx;
                        ptr   <= arb_idx;
                    end
                end
                ACTIVE: begin
                    // Release when both streams are finished, counting a
                    // completion happening in this very cycle.
                    if ((hdr_done | hdr_hs) && (pkt_done | pkt_hs)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        grant    <= '0;
                        hdr_done <= 1'b0;
                        pkt_done <= 1'b0;
                    end else begin
                        if (hdr_hs) hdr_done <= 1'b1;
                        if (pkt_hs) pkt_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
